// File: rtl/ball_game_ctrl.sv
// Rally sequencer for the single-ball game: serve/play/miss sequencing, crash
// vector generation for the ball mover, and score/lives bookkeeping.
module ball_game_ctrl #(
  parameter logic [9:0] X_MIN    = 10'd8,
  parameter logic [9:0] X_MAX    = 10'd632,
  parameter logic [9:0] Y_MIN    = 10'd8,
  parameter logic [9:0] Y_MAX    = 10'd472,
  parameter logic [9:0] BALL_SZ  = 10'd8,
  parameter logic [9:0] PAD_X    = 10'd16,
  parameter logic [9:0] PAD_H    = 10'd64,
  parameter logic [3:0] STEP_DIV = 4'd1,
  parameter logic [7:0] SERVE_FR = 8'd60,
  parameter logic [1:0] LIVES    = 2'd3
) (
  input  logic       iVGA_CLK,
  input  logic       iRST,
  input  logic       iFrame,
  input  logic       iStart,
  input  logic [9:0] iBall_x,
  input  logic [9:0] iBall_y,
  input  logic [9:0] iPad_y,
  output logic [3:0] oCrash,
  output logic       oStep,
  output logic       oServe,
  output logic [2:0] oState,
  output logic [7:0] oScore,
  output logic [1:0] oLives,
  output logic       oGame_over
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SERVE = 3'd1,
    ST_PLAY  = 3'd2,
    ST_MISS  = 3'd3,
    ST_OVER  = 3'd4
  } state_t;

  state_t      state_q, state_d;
  logic [7:0]  serve_cnt_q, serve_cnt_d;
  logic [3:0]  step_cnt_q, step_cnt_d;
  logic [7:0]  score_q, score_d;
  logic [1:0]  lives_q, lives_d;
  logic [3:0]  crash_q, crash_d;
  logic        step_q, step_d;
  logic        serve_q, serve_d;
  logic        hit_prev_q, hit_prev_d;
  logic        game_over_q, game_over_d;

  logic [10:0] bx_end_s, by_end_s, pad_end_s;
  logic        up_s, down_s, right_s, hit_s, miss_s;

  // Geometry is evaluated in 11 bits so far-right/bottom positions never wrap.
  always_comb begin
    bx_end_s  = {1'b0, iBall_x} + {1'b0, BALL_SZ};
    by_end_s  = {1'b0, iBall_y} + {1'b0, BALL_SZ};
    pad_end_s = {1'b0, iPad_y} + {1'b0, PAD_H};
    up_s      = (iBall_y <= Y_MIN);
    down_s    = (by_end_s >= {1'b0, Y_MAX});
    right_s   = (bx_end_s >= {1'b0, X_MAX});
    hit_s     = (iBall_x <= PAD_X) && (by_end_s > {1'b0, iPad_y}) &&
                ({1'b0, iBall_y} < pad_end_s);
    miss_s    = (iBall_x <= X_MIN) && !hit_s;
  end

  // Next-state, counters and registered-output values.
  always_comb begin
    state_d     = state_q;
    serve_cnt_d = serve_cnt_q;
    step_cnt_d  = 4'd0;
    score_d     = score_q;
    lives_d     = lives_q;
    crash_d     = 4'b0000;
    step_d      = 1'b0;
    serve_d     = 1'b0;
    hit_prev_d  = 1'b0;

    case (state_q)
      ST_IDLE, ST_OVER: begin
        if (iStart) begin
          state_d     = ST_SERVE;
          score_d     = 8'd0;
          lives_d     = LIVES;
          serve_d     = 1'b1;
          serve_cnt_d = 8'd0;
        end else begin
          state_d     = state_q;
        end
      end

      ST_SERVE: begin
        if (iFrame) begin
          if (serve_cnt_q >= (SERVE_FR - 8'd1)) begin
            state_d     = ST_PLAY;
            serve_cnt_d = 8'd0;
          end else begin
            serve_cnt_d = serve_cnt_q + 8'd1;
          end
        end else begin
          serve_cnt_d = serve_cnt_q;
        end
      end

      ST_PLAY: begin
        // A miss suppresses the crash vector and scoring for its cycle.
        if (miss_s) begin
          state_d = ST_MISS;
        end else begin
          crash_d    = {hit_s, right_s, up_s, down_s};
          hit_prev_d = hit_s;
          if (hit_s && !hit_prev_q && (score_q != 8'd255)) begin
            score_d = score_q + 8'd1;
          end else begin
            score_d = score_q;
          end
          if (iFrame) begin
            if (step_cnt_q >= (STEP_DIV - 4'd1)) begin
              step_d     = 1'b1;
              step_cnt_d = 4'd0;
            end else begin
              step_cnt_d = step_cnt_q + 4'd1;
            end
          end else begin
            step_cnt_d = step_cnt_q;
          end
        end
      end

      ST_MISS: begin
        if (lives_q == 2'd0) begin
          lives_d = 2'd0;
        end else begin
          lives_d = lives_q - 2'd1;
        end
        if (lives_q <= 2'd1) begin
          state_d = ST_OVER;
        end else begin
          state_d     = ST_SERVE;
          serve_d     = 1'b1;
          serve_cnt_d = 8'd0;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    game_over_d = (state_d == ST_OVER);
  end

  // State and output registers.
  always_ff @(posedge iVGA_CLK or posedge iRST) begin
    if (iRST) begin
      state_q     <= ST_IDLE;
      serve_cnt_q <= 8'd0;
      step_cnt_q  <= 4'd0;
      score_q     <= 8'd0;
      lives_q     <= LIVES;
      crash_q     <= 4'b0000;
      step_q      <= 1'b0;
      serve_q     <= 1'b0;
      hit_prev_q  <= 1'b0;
      game_over_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      serve_cnt_q <= serve_cnt_d;
      step_cnt_q  <= step_cnt_d;
      score_q     <= score_d;
      lives_q     <= lives_d;
      crash_q     <= crash_d;
      step_q      <= step_d;
      serve_q     <= serve_d;
      hit_prev_q  <= hit_prev_d;
      game_over_q <= game_over_d;
    end
  end

  assign oState     = state_q;
  assign oCrash     = crash_q;
  assign oStep      = step_q;
  assign oServe     = serve_q;
  assign oScore     = score_q;
  assign oLives     = lives_q;
  assign oGame_over = game_over_q;

endmodule
